calc_controle_soma: RTL and testbench

- Keypad-driven sequencer for the calculator's 4-bit single-digit adder (operands 0-9, sum 0-15).
- Collects operand A, the '+' operator and operand B from one-cycle key events, then drives the adder operands and its enable for a settle window.
- Captures the adder result into a display register and flags sums above 15, which the adder does not cover.
- Sits between the keypad decoder and the display driver.

---
 rtl/calc_controle_soma.sv | 196 +++++++++++++++++++
 tb/tb_calc_controle_soma.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_controle_soma.sv
`default_nettype none
// ============================================================================
// calc_controle_soma : keypad sequencer driving the single-digit 4-bit adder
// Rev 1.0
// ============================================================================
module calc_controle_soma #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_aceita,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       soma_en,
  input  logic [3:0] soma_s,
  output logic [3:0] disp,
  output logic       disp_valid,
  output logic       erro,
  output logic       ocupado
);

  typedef enum logic [2:0] {
    OCIOSO    = 3'd0,
    ENTRA_A   = 3'd1,
    ESPERA_OP = 3'd2,
    ENTRA_B   = 3'd3,
    CALCULA   = 3'd4,
    MOSTRA    = 3'd5,
    ERRO      = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);
  localparam logic [3:0]       C_KEY_MAIS  = 4'd10;
  localparam logic [3:0]       C_KEY_IGUAL = 4'd11;
  localparam logic [3:0]       C_KEY_LIMPA = 4'd12;

  state_t           state_q, state_d;
  logic [3:0]       op_a_q, op_a_d, op_b_q, op_b_d, disp_q, disp_d;
  logic             disp_valid_q, disp_valid_d, erro_q, erro_d;
  logic             ocupado_q, ocupado_d, soma_en_q, soma_en_d;
  logic             key_aceita_q, key_aceita_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       is_digit;
  logic [3:0] sum_a;
  logic [4:0] sum;
  logic       overflow;

  assign is_digit = (key_code <= 4'd9);
  // In MOSTRA the left operand of the pending sum is the displayed result.
  assign sum_a    = (state_q == MOSTRA) ? disp_q : op_a_q;
  assign sum      = {1'b0, sum_a} + {1'b0, op_b_q};
  assign overflow = sum[4];

  always_comb begin
    state_d      = state_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    disp_d       = disp_q;
    disp_valid_d = disp_valid_q;
    erro_d       = erro_q;
    ocupado_d    = ocupado_q;
    soma_en_d    = soma_en_q;
    key_aceita_d = 1'b0;
    cnt_d        = cnt_q;

    if (state_q == CALCULA) begin
      cnt_d = cnt_q + C_CNT_ONE;
      if (cnt_q == C_CNT_LAST) begin
        disp_d       = soma_s;
        disp_valid_d = 1'b1;
        soma_en_d    = 1'b0;
        ocupado_d    = 1'b0;
        state_d      = MOSTRA;
      end
    end else if (key_valid) begin
      if (key_code == C_KEY_LIMPA) begin
        state_d      = OCIOSO;
        op_a_d       = 4'd0;
        op_b_d       = 4'd0;
        disp_d       = 4'd0;
        disp_valid_d = 1'b0;
        erro_d       = 1'b0;
        ocupado_d    = 1'b0;
        soma_en_d    = 1'b0;
        cnt_d        = '0;
        key_aceita_d = 1'b1;
      end else begin
        case (state_q)
          OCIOSO, ENTRA_A: begin
            if (is_digit) begin
              op_a_d       = key_code;
              disp_d       = key_code;
              disp_valid_d = 1'b0;
              erro_d       = 1'b0;
              state_d      = ENTRA_A;
              key_aceita_d = 1'b1;
            end else if (key_code == C_KEY_MAIS && state_q == ENTRA_A) begin
              state_d      = ESPERA_OP;
              key_aceita_d = 1'b1;
            end
          end
          ESPERA_OP, ENTRA_B: begin
            if (is_digit) begin
              op_b_d       = key_code;
              disp_d       = key_code;
              disp_valid_d = 1'b0;
              state_d      = ENTRA_B;
              key_aceita_d = 1'b1;
            end else if (key_code == C_KEY_IGUAL && state_q == ENTRA_B) begin
              key_aceita_d = 1'b1;
              if (overflow) begin
                erro_d  = 1'b1;
                disp_d  = 4'd0;
                state_d = ERRO;
              end else begin
                soma_en_d = 1'b1;
                ocupado_d = 1'b1;
                cnt_d     = '0;
                state_d   = CALCULA;
              end
            end
          end
          MOSTRA: begin
            key_aceita_d = is_digit || key_code == C_KEY_MAIS || key_code == C_KEY_IGUAL;
            if (is_digit) begin
              op_a_d       = key_code;
              op_b_d       = 4'd0;
              disp_d       = key_code;
              disp_valid_d = 1'b0;
              state_d      = ENTRA_A;
            end else if (key_code == C_KEY_MAIS && disp_q <= 4'd9) begin
              op_a_d  = disp_q;
              state_d = ESPERA_OP;
            end else if ((key_code == C_KEY_MAIS) ||
                         (key_code == C_KEY_IGUAL && overflow)) begin
              // Error entry blanks the display so a stale result is never shown as valid.
              erro_d       = 1'b1;
              disp_d       = 4'd0;
              disp_valid_d = 1'b0;
              state_d      = ERRO;
            end else if (key_code == C_KEY_IGUAL) begin
              op_a_d    = disp_q;
              soma_en_d = 1'b1;
              ocupado_d = 1'b1;
              cnt_d     = '0;
              state_d   = CALCULA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= OCIOSO;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      disp_q       <= 4'd0;
      disp_valid_q <= 1'b0;
      erro_q       <= 1'b0;
      ocupado_q    <= 1'b0;
      soma_en_q    <= 1'b0;
      key_aceita_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      disp_q       <= disp_d;
      disp_valid_q <= disp_valid_d;
      erro_q       <= erro_d;
      ocupado_q    <= ocupado_d;
      soma_en_q    <= soma_en_d;
      key_aceita_q <= key_aceita_d;
      cnt_q        <= cnt_d;
    end
  end

  assign key_aceita = key_aceita_q;
  assign op_a       = op_a_q;
  assign op_b       = op_b_q;
  assign soma_en    = soma_en_q;
  assign disp       = disp_q;
  assign disp_valid = disp_valid_q;
  assign erro       = erro_q;
  assign ocupado    = ocupado_q;

endmodule
`default_nettype wire

// File: tb/tb_calc_controle_soma.sv
`default_nettype none
// ============================================================================
// tb_calc_controle_soma : bench for calc_controle_soma (SETTLE 2 and SETTLE 4)
// Rev 1.0
// ============================================================================
module tb_calc_controle_soma;

  localparam int SETTLE_A = 2;
  localparam int SETTLE_B = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;

  logic       ka0, se0, dv0, er0, oc0;
  logic [3:0] oa0, ob0, ss0, dp0;
  logic       ka1, se1, dv1, er1, oc1;
  logic [3:0] oa1, ob1, ss1, dp1;

  always #5 clk = ~clk;

  // Adder stand-in: garbage unless enabled, so a mistimed sample shows up.
  assign ss0 = se0 ? 4'(oa0 + ob0) : ~4'(oa0 + ob0);
  assign ss1 = se1 ? 4'(oa1 + ob1) : ~4'(oa1 + ob1);

  calc_controle_soma #(.SETTLE_CYCLES(SETTLE_A), .CNT_W(4)) u0 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_aceita(ka0), .op_a(oa0), .op_b(ob0), .soma_en(se0), .soma_s(ss0),
    .disp(dp0), .disp_valid(dv0), .erro(er0), .ocupado(oc0));

  calc_controle_soma #(.SETTLE_CYCLES(SETTLE_B), .CNT_W(4)) u1 (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
    .key_aceita(ka1), .op_a(oa1), .op_b(ob1), .soma_en(se1), .soma_s(ss1),
    .disp(dp1), .disp_valid(dv1), .erro(er1), .ocupado(oc1));

  typedef struct {
    int key;
    bit acc;
    bit calc;
    int a;
    int b;
    int d;
    bit dv;
    bit er;
  } vec_t;

  typedef enum int {P_IDLE, P_A, P_OP, P_B, P_SHOW, P_ERR} phase_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  vec_t   vecs[$];
  phase_t m_ph;
  int     m_a, m_b, m_d;
  bit     m_dv, m_er;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input int k, input bit acc, input bit calc,
                              input int a, input int b, input int d, input bit dv, input bit er);
    vec_t v;
    v.key = k; v.acc = acc; v.calc = calc; v.a = a; v.b = b; v.d = d; v.dv = dv; v.er = er;
    return v;
  endfunction

  // ---------------- reference model: one call per key event ----------------
  function automatic void m_clear();
    m_ph = P_IDLE; m_a = 0; m_b = 0; m_d = 0; m_dv = 1'b0; m_er = 1'b0;
  endfunction

  function automatic void m_error();
    m_er = 1'b1; m_d = 0; m_dv = 1'b0; m_ph = P_ERR;
  endfunction

  function automatic vec_t model_step(input int k);
    vec_t v;
    int   s;
    v.key = k; v.acc = 1'b0; v.calc = 1'b0;
    if (k == 12) begin
      m_clear();
      v.acc = 1'b1;
    end else if (k <= 9) begin
      if (m_ph == P_IDLE || m_ph == P_A || m_ph == P_SHOW) begin
        if (m_ph == P_SHOW) m_b = 0;
        m_a = k; m_d = k; m_dv = 1'b0; m_er = 1'b0; m_ph = P_A; v.acc = 1'b1;
      end else if (m_ph == P_OP || m_ph == P_B) begin
        m_b = k; m_d = k; m_dv = 1'b0; m_ph = P_B; v.acc = 1'b1;
      end
    end else if (k == 10) begin
      if (m_ph == P_A) begin
        m_ph = P_OP; v.acc = 1'b1;
      end else if (m_ph == P_SHOW) begin
        v.acc = 1'b1;
        if (m_d <= 9) begin m_a = m_d; m_ph = P_OP; end
        else m_error();
      end
    end else if (k == 11) begin
      if (m_ph == P_B || m_ph == P_SHOW) begin
        v.acc = 1'b1;
        s = ((m_ph == P_SHOW) ? m_d : m_a) + m_b;
        if (s > 15) m_error();
        else begin
          if (m_ph == P_SHOW) m_a = m_d;
          m_d = s; m_dv = 1'b1; m_ph = P_SHOW; v.calc = 1'b1;
        end
      end
    end
    v.a = m_a; v.b = m_b; v.d = m_d; v.dv = m_dv; v.er = m_er;
    return v;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_key(input vec_t v, input int idx);
    int cyc;
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'(v.key);
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("key_aceita", idx, 32'(ka0), 32'(v.acc));
    chk("soma_en_start", idx, 32'(se0), 32'(v.calc));
    if (v.calc) begin
      cyc = 0;
      while (se0 === 1'b1 && cyc < 64) begin
        cyc++;
        chk("op_a_hold", idx, 32'(oa0), v.a);
        chk("op_b_hold", idx, 32'(ob0), v.b);
        chk("ocupado_hold", idx, 32'(oc0), 32'd1);
        @(negedge clk);
      end
      chk("settle_len", idx, cyc, SETTLE_A);
      chk("key_aceita_after", idx, 32'(ka0), 32'd0);
    end
    chk("op_a", idx, 32'(oa0), v.a);
    chk("op_b", idx, 32'(ob0), v.b);
    chk("disp", idx, 32'(dp0), v.d);
    chk("disp_valid", idx, 32'(dv0), 32'(v.dv));
    chk("erro", idx, 32'(er0), 32'(v.er));
    chk("ocupado", idx, 32'(oc0), 32'd0);
    chk("soma_en", idx, 32'(se0), 32'd0);
  endtask

  task automatic drive_key(input int k);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'(k);
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
  endtask

  task automatic do_reset(input int idx);
    @(negedge clk);
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'd0;
    @(negedge clk);
    chk("rst_outs0", idx, {20'd0, ka0, se0, dv0, er0, oc0, 3'd0, oa0, ob0, dp0} , 32'd0);
    chk("rst_outs1", idx, {20'd0, ka1, se1, dv1, er1, oc1, 3'd0, oa1, ob1, dp1} , 32'd0);
    rst_n = 1'b1;
    m_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int k;
    int r;

    // Expected values after each key (after the settle window when a sum runs).
    //                 key acc calc a  b  disp dv er
    vecs.push_back(mk(3,  1, 0, 3, 0, 3,  0, 0));
    vecs.push_back(mk(10, 1, 0, 3, 0, 3,  0, 0));
    vecs.push_back(mk(4,  1, 0, 3, 4, 4,  0, 0));
    vecs.push_back(mk(11, 1, 1, 3, 4, 7,  1, 0));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(9,  1, 0, 9, 0, 9,  0, 0));
    vecs.push_back(mk(10, 1, 0, 9, 0, 9,  0, 0));
    vecs.push_back(mk(7,  1, 0, 9, 7, 7,  0, 0));
    vecs.push_back(mk(11, 1, 0, 9, 7, 0,  0, 1));
    vecs.push_back(mk(5,  0, 0, 9, 7, 0,  0, 1));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(2,  1, 0, 2, 0, 2,  0, 0));
    vecs.push_back(mk(5,  1, 0, 5, 0, 5,  0, 0));
    vecs.push_back(mk(10, 1, 0, 5, 0, 5,  0, 0));
    vecs.push_back(mk(1,  1, 0, 5, 1, 1,  0, 0));
    vecs.push_back(mk(6,  1, 0, 5, 6, 6,  0, 0));
    vecs.push_back(mk(11, 1, 1, 5, 6, 11, 1, 0));
    vecs.push_back(mk(10, 1, 0, 5, 6, 0,  0, 1));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(4,  1, 0, 4, 0, 4,  0, 0));
    vecs.push_back(mk(10, 1, 0, 4, 0, 4,  0, 0));
    vecs.push_back(mk(4,  1, 0, 4, 4, 4,  0, 0));
    vecs.push_back(mk(11, 1, 1, 4, 4, 8,  1, 0));
    vecs.push_back(mk(10, 1, 0, 8, 4, 8,  1, 0));
    vecs.push_back(mk(1,  1, 0, 8, 1, 1,  0, 0));
    vecs.push_back(mk(11, 1, 1, 8, 1, 9,  1, 0));
    vecs.push_back(mk(11, 1, 1, 9, 1, 10, 1, 0));
    vecs.push_back(mk(13, 0, 0, 9, 1, 10, 1, 0));
    vecs.push_back(mk(2,  1, 0, 2, 0, 2,  0, 0));
    vecs.push_back(mk(13, 0, 0, 2, 0, 2,  0, 0));
    vecs.push_back(mk(10, 1, 0, 2, 0, 2,  0, 0));
    vecs.push_back(mk(14, 0, 0, 2, 0, 2,  0, 0));
    vecs.push_back(mk(3,  1, 0, 2, 3, 3,  0, 0));
    vecs.push_back(mk(15, 0, 0, 2, 3, 3,  0, 0));
    vecs.push_back(mk(11, 1, 1, 2, 3, 5,  1, 0));
    vecs.push_back(mk(11, 1, 1, 5, 3, 8,  1, 0));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(14, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(10, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(11, 0, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(7,  1, 0, 7, 0, 7,  0, 0));
    vecs.push_back(mk(11, 0, 0, 7, 0, 7,  0, 0));
    vecs.push_back(mk(10, 1, 0, 7, 0, 7,  0, 0));
    vecs.push_back(mk(10, 0, 0, 7, 0, 7,  0, 0));
    vecs.push_back(mk(11, 0, 0, 7, 0, 7,  0, 0));
    vecs.push_back(mk(8,  1, 0, 7, 8, 8,  0, 0));
    vecs.push_back(mk(10, 0, 0, 7, 8, 8,  0, 0));
    vecs.push_back(mk(11, 1, 1, 7, 8, 15, 1, 0));
    vecs.push_back(mk(10, 1, 0, 7, 8, 0,  0, 1));
    vecs.push_back(mk(10, 0, 0, 7, 8, 0,  0, 1));
    vecs.push_back(mk(11, 0, 0, 7, 8, 0,  0, 1));
    vecs.push_back(mk(13, 0, 0, 7, 8, 0,  0, 1));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(5,  1, 0, 5, 0, 5,  0, 0));
    vecs.push_back(mk(10, 1, 0, 5, 0, 5,  0, 0));
    vecs.push_back(mk(5,  1, 0, 5, 5, 5,  0, 0));
    vecs.push_back(mk(11, 1, 1, 5, 5, 10, 1, 0));
    vecs.push_back(mk(11, 1, 1, 10, 5, 15, 1, 0));
    vecs.push_back(mk(11, 1, 0, 10, 5, 0, 0, 1));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(4,  1, 0, 4, 0, 4,  0, 0));
    vecs.push_back(mk(10, 1, 0, 4, 0, 4,  0, 0));
    vecs.push_back(mk(5,  1, 0, 4, 5, 5,  0, 0));
    vecs.push_back(mk(11, 1, 1, 4, 5, 9,  1, 0));
    vecs.push_back(mk(10, 1, 0, 9, 5, 9,  1, 0));
    vecs.push_back(mk(0,  1, 0, 9, 0, 0,  0, 0));
    vecs.push_back(mk(11, 1, 1, 9, 0, 9,  1, 0));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(6,  1, 0, 6, 0, 6,  0, 0));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));
    vecs.push_back(mk(6,  1, 0, 6, 0, 6,  0, 0));
    vecs.push_back(mk(10, 1, 0, 6, 0, 6,  0, 0));
    vecs.push_back(mk(12, 1, 0, 0, 0, 0,  0, 0));

    do_reset(0);
    for (int i = 0; i < vecs.size(); i++) send_key(vecs[i], i);

    // Key pulsed mid-sum, then a key landing on the edge the sum completes.
    do_reset(1);
    send_key(model_step(3), 500);
    send_key(model_step(10), 501);
    send_key(model_step(4), 502);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd11;
    @(negedge clk);
    key_code = 4'd9;
    chk("h1_eq_aceita", 0, 32'(ka0), 32'd1);
    chk("h1_soma_en0", 0, 32'(se0), 32'd1);
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("h1_digit_ignored", 0, 32'(ka0), 32'd0);
    chk("h1_soma_en1", 0, 32'(se0), 32'd1);
    chk("h1_op_a_hold", 0, 32'(oa0), 32'd3);
    @(negedge clk);
    chk("h1_soma_en_off", 0, 32'(se0), 32'd0);
    chk("h1_disp", 0, 32'(dp0), 32'd7);
    chk("h1_disp_valid", 0, 32'(dv0), 32'd1);
    chk("h1_op_a", 0, 32'(oa0), 32'd3);
    void'(model_step(11));
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd11;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("h2_eq_aceita", 0, 32'(ka0), 32'd1);
    chk("h2_soma_en0", 0, 32'(se0), 32'd1);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd5;
    chk("h2_soma_en1", 0, 32'(se0), 32'd1);
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("h2_exit_key_ignored", 0, 32'(ka0), 32'd0);
    chk("h2_soma_en_off", 0, 32'(se0), 32'd0);
    chk("h2_disp", 0, 32'(dp0), 32'd11);
    chk("h2_op_a", 0, 32'(oa0), 32'd7);
    void'(model_step(11));
    send_key(model_step(2), 503);

    // Reset asserted in the second cycle of a sum.
    send_key(model_step(12), 510);
    send_key(model_step(1), 511);
    send_key(model_step(10), 512);
    send_key(model_step(2), 513);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd11;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("h3_soma_en0", 0, 32'(se0), 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("h3_async_soma_en", 0, 32'(se0), 32'd0);
    chk("h3_async_outs", 0, {20'd0, ka0, se0, dv0, er0, oc0, 3'd0, oa0, ob0, dp0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_clear();
    send_key(model_step(4), 514);

    // Randomized keys against the reference model.
    do_reset(2);
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      k = int'($urandom_range(0, 9));
      else if (r < 70) k = 10;
      else if (r < 85) k = 11;
      else if (r < 92) k = 12;
      else             k = int'($urandom_range(13, 15));
      send_key(model_step(k), 1000 + i);
    end

    // Longer settle window, digit pulsed during the sum.
    do_reset(3);
    drive_key(3);
    drive_key(10);
    drive_key(4);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd11;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd0;
    chk("b_eq_aceita", 0, 32'(ka1), 32'd1);
    cyc = 0;
    while (se1 === 1'b1 && cyc < 64) begin
      cyc++;
      if (cyc == 1) begin
        key_valid = 1'b1; key_code = 4'd9;
      end else begin
        key_valid = 1'b0; key_code = 4'd0;
        if (cyc == 2) chk("b_digit_ignored", 0, 32'(ka1), 32'd0);
      end
      chk("b_op_a_hold", cyc, 32'(oa1), 32'd3);
      chk("b_op_b_hold", cyc, 32'(ob1), 32'd4);
      @(negedge clk);
    end
    key_valid = 1'b0; key_code = 4'd0;
    chk("b_settle_len", 0, cyc, SETTLE_B);
    chk("b_disp", 0, 32'(dp1), 32'd7);
    chk("b_disp_valid", 0, 32'(dv1), 32'd1);
    chk("b_erro", 0, 32'(er1), 32'd0);
    chk("b_ocupado", 0, 32'(oc1), 32'd0);
    chk("b_op_a", 0, 32'(oa1), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
